// File: rtl/lut_encoder.sv
// Purpose: run-time loadable key->code lookup table with hit flag, lowest matching index and hit/miss counters.
// Latency: 2 cycles (accept edge N, result valid after edge N+1), 1 word/cycle sustained.
// Backpressure: out_ready=0 holds the output stage; in_ready drops only when both stages hold a word.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_key/
//   cfg_code/cfg_en                 table write port (addresses >= DEPTH ignored)
//   in_valid/in_ready/in_data       lookup key stream
//   out_valid/out_ready/out_code/
//   out_hit/out_idx                 result stream
//   hit_cnt/miss_cnt                saturating counts of accepted results
module lut_encoder #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 8,
    parameter int                 IDXW      = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]   MISS_CODE = '0,
    parameter int                 CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_addr,
    input  logic [WIDTH-1:0] cfg_key,
    input  logic [WIDTH-1:0] cfg_code,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_code,
    output logic             out_hit,
    output logic [IDXW-1:0]  out_idx,
    output logic [CNTW-1:0]  hit_cnt,
    output logic [CNTW-1:0]  miss_cnt
);

    typedef struct packed {
        logic             hit;
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] code;
    } res_t;

    localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);

    // Table storage. Only the enables are reset; a disabled entry never matches,
    // so stale keys/codes are harmless.
    logic [WIDTH-1:0] tbl_key  [DEPTH];
    logic [WIDTH-1:0] tbl_code [DEPTH];
    logic [DEPTH-1:0] tbl_en;

    logic addr_ok;
    assign addr_ok = ({1'b0, cfg_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_en <= '0;
        end else if (cfg_we && addr_ok) begin
            tbl_en[cfg_addr] <= cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && addr_ok) begin
            tbl_key[cfg_addr]  <= cfg_key;
            tbl_code[cfg_addr] <= cfg_code;
        end
    end

    // Parallel compare + priority encode. Scanning from the top down lets the
    // lowest matching index overwrite any higher one. Reads the registered
    // table, so a same-cycle write is seen only by later lookups.
    res_t lk_res;

    always_comb begin
        lk_res.hit  = 1'b0;
        lk_res.idx  = '0;
        lk_res.code = MISS_CODE;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_en[i] && (tbl_key[i] == in_data)) begin
                lk_res.hit  = 1'b1;
                lk_res.idx  = IDXW'(i);
                lk_res.code = tbl_code[i];
            end
        end
    end

    // Handshake: each stage advances when it is empty or its consumer takes the word.
    logic s1_valid;
    res_t s1_res;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_res    <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_hit   <= 1'b0;
            out_idx   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_res <= lk_res;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_code <= s1_res.code;
                    out_hit  <= s1_res.hit;
                    out_idx  <= s1_res.idx;
                end
            end
        end
    end

    // Counters count results actually taken downstream and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + CNTW'(1);
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_encoder.sv
// Purpose: self-checking bench for lut_encoder using a scoreboard of expected results.
// Latency: checks the 2-cycle accept-to-output timing and 1 word/cycle drain.
// Backpressure: exercises out_ready stalls, in_ready deassertion and reset with words in flight.
module tb_lut_encoder;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int IDXW  = 3;
    localparam int CNTW  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] code;
        logic             hit;
        logic [IDXW-1:0]  idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [IDXW-1:0]  cfg_addr = '0;
    logic [WIDTH-1:0] cfg_key = '0;
    logic [WIDTH-1:0] cfg_code = '0;
    logic             cfg_en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_code;
    logic             out_hit;
    logic [IDXW-1:0]  out_idx;
    logic [CNTW-1:0]  hit_cnt;
    logic [CNTW-1:0]  miss_cnt;

    lut_encoder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW), .MISS_CODE('0), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key),
        .cfg_code(cfg_code), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_hit(out_hit), .out_idx(out_idx),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference table and scoreboard state.
    logic [WIDTH-1:0] m_key  [DEPTH];
    logic [WIDTH-1:0] m_code [DEPTH];
    logic [DEPTH-1:0] m_en = '0;
    exp_t             exp_q[$];
    logic [WIDTH-1:0] obs_codes[$];
    logic [IDXW-1:0]  last_idx;
    logic             last_hit;
    logic [CNTW-1:0]  exp_hit = '0;
    logic [CNTW-1:0]  exp_miss = '0;

    function automatic exp_t model_lookup(input logic [WIDTH-1:0] key);
        exp_t r;
        r.code = '0;
        r.hit  = 1'b0;
        r.idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r.hit && m_en[i] && m_key[i] == key) begin
                r.code = m_code[i];
                r.hit  = 1'b1;
                r.idx  = IDXW'(i);
            end
        end
        return r;
    endfunction

    // Inputs change 1 time unit after posedge, so at negedge both the inputs
    // and the registered outputs are stable and describe the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_en     = '0;
            exp_hit  = '0;
            exp_miss = '0;
        end else begin
            n_vec++;
            if (hit_cnt !== exp_hit) begin
                n_err++;
                $display("FAIL hit_cnt: got %0d expected %0d at %0t", hit_cnt, exp_hit, $time);
            end
            n_vec++;
            if (miss_cnt !== exp_miss) begin
                n_err++;
                $display("FAIL miss_cnt: got %0d expected %0d at %0t", miss_cnt, exp_miss, $time);
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: code %h with empty scoreboard at %0t", out_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_code, out_hit, out_idx} !== {e.code, e.hit, e.idx}) begin
                        n_err++;
                        $display("FAIL result: got code=%h hit=%b idx=%0d expected code=%h hit=%b idx=%0d at %0t",
                                 out_code, out_hit, out_idx, e.code, e.hit, e.idx, $time);
                    end
                end
                obs_codes.push_back(out_code);
                last_hit = out_hit;
                last_idx = out_idx;
                if (out_hit) begin
                    if (exp_hit != '1) exp_hit = exp_hit + 4'd1;
                end else begin
                    if (exp_miss != '1) exp_miss = exp_miss + 4'd1;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_lookup(in_data));
            if (cfg_we && int'(cfg_addr) < DEPTH) begin
                m_key[cfg_addr]  = cfg_key;
                m_code[cfg_addr] = cfg_code;
                m_en[cfg_addr]   = cfg_en;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [IDXW-1:0] a, input logic [WIDTH-1:0] k,
                             input logic [WIDTH-1:0] c, input logic en);
        cfg_we = 1'b1; cfg_addr = a; cfg_key = k; cfg_code = c; cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] key);
        int n = 0;
        in_valid = 1'b1;
        in_data  = key;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({out_valid, out_code, out_hit, out_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b code=%h hit=%b idx=%0d required all 0",
                     out_valid, out_code, out_hit, out_idx);
        end
        n_vec++;
        if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", hit_cnt, miss_cnt);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        cfg_write(3'd0, 32'd0, 32'd1423, 1'b1);
        cfg_write(3'd1, 32'd123, 32'hFFFF_FA70, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd0;
        tick();                      // edge N: key 0 accepted
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid got %b required 0 one edge after accept", out_valid);
        end
        in_data = 32'd123;
        tick();                      // edge N+1: key 0 reaches output, key 123 accepted
        n_vec++;
        if (out_valid !== 1'b1 || out_code !== 32'd1423) begin
            n_err++;
            $display("FAIL latency_two: got valid=%b code=%h required 1/%h", out_valid, out_code, 32'd1423);
        end
        in_valid = 1'b0;
        drain();
        n_vec++;
        if (hit_cnt !== 4'd2) begin
            n_err++;
            $display("FAIL basic_hit_cnt: got %0d required 2", hit_cnt);
        end
    endtask

    task automatic test_miss();
        send(32'd7000);
        drain();
        n_vec++;
        if (miss_cnt !== 4'd1 || last_hit !== 1'b0 || obs_codes[obs_codes.size()-1] !== 32'd0) begin
            n_err++;
            $display("FAIL miss: got miss_cnt=%0d hit=%b code=%h required 1/0/0",
                     miss_cnt, last_hit, obs_codes[obs_codes.size()-1]);
        end
    endtask

    task automatic test_priority();
        cfg_write(3'd2, 32'd1023, 32'd5, 1'b1);
        cfg_write(3'd5, 32'd1023, 32'd9, 1'b1);
        send(32'd1023);
        drain();
        n_vec++;
        if (obs_codes[obs_codes.size()-1] !== 32'd5 || last_idx !== 3'd2) begin
            n_err++;
            $display("FAIL priority_low: got code=%0d idx=%0d required 5/2", obs_codes[obs_codes.size()-1], last_idx);
        end
        cfg_write(3'd2, 32'd1023, 32'd5, 1'b0);
        send(32'd1023);
        drain();
        n_vec++;
        if (obs_codes[obs_codes.size()-1] !== 32'd9 || last_idx !== 3'd5) begin
            n_err++;
            $display("FAIL priority_disabled: got code=%0d idx=%0d required 9/5", obs_codes[obs_codes.size()-1], last_idx);
        end
    endtask

    task automatic test_back_to_back();
        obs_codes.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd0;
        tick();
        in_data = 32'd123;
        tick();
        in_data = 32'd7000;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 32'd1423 || out_idx !== 3'd0) begin
                n_err++;
                $display("FAIL stall_hold: got ready=%b valid=%b code=%h idx=%0d required 0/1/%h/0",
                         in_ready, out_valid, out_code, out_idx, 32'd1423);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();                      // third word accepted as the first leaves
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL drain_rate: out_valid got %b required 1 on drain cycle %0d", out_valid, i);
            end
            tick();
        end
        drain();
        n_vec++;
        if (obs_codes.size() != 3 || obs_codes[0] !== 32'd1423 || obs_codes[1] !== 32'hFFFF_FA70
            || obs_codes[2] !== 32'd0) begin
            n_err++;
            $display("FAIL order: got %0d results, required 3 in order %h,%h,%h",
                     obs_codes.size(), 32'd1423, 32'hFFFF_FA70, 32'd0);
        end
    endtask

    task automatic test_same_cycle_write();
        obs_codes.delete();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_key = 32'd0; cfg_code = 32'd77; cfg_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd0;
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        drain();
        n_vec++;
        if (obs_codes.size() != 2 || obs_codes[0] !== 32'd1423 || obs_codes[1] !== 32'd77) begin
            n_err++;
            $display("FAIL write_vs_lookup: got %0d results, required %0d then %0d",
                     obs_codes.size(), 1423, 77);
        end
    endtask

    task automatic test_saturate();
        in_valid = 1'b1;
        in_data  = 32'd123;
        for (int i = 0; i < 20; i++) begin
            int n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        drain();
        n_vec++;
        if (hit_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL hit_saturate: got %0d required 15", hit_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd0;
        tick();
        in_data = 32'd123;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_inflight: got valid=%b hit_cnt=%0d miss_cnt=%0d required 0/0/0",
                     out_valid, hit_cnt, miss_cnt);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send(32'd123);
        drain();
        n_vec++;
        if (last_hit !== 1'b0 || miss_cnt !== 4'd1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_entries: got hit=%b miss_cnt=%0d required 0/1", last_hit, miss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miss();
        test_priority();
        test_back_to_back();
        test_same_cycle_write();
        test_saturate();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/lut_encoder.md
Name: lut_encoder

Overview:
- Programmable key-to-code encoder.
- Replaces fixed hard-coded compare chains with a run-time loadable table of DEPTH {key, code} entries.
- Streams words through a 2-stage valid/ready pipeline. Each output carries the mapped code, a hit flag and the matching index, and the block keeps saturating hit/miss counters.
- Sits between a data source and downstream logic in the datapath. Table is loaded by a control/config master.

Parameters:
- WIDTH, 32, key and code width in bits
- DEPTH, 8, number of table entries (2..64)
- IDXW, $clog2(DEPTH), index width
- MISS_CODE, 0, code emitted when no entry matches
- CNTW, 16, width of hit/miss counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  IDXW  entry to write
- cfg_key  in  WIDTH  key to store
- cfg_code  in  WIDTH  code to store
- cfg_en  in  1  entry enable bit to store (0 = invalidate entry)
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_data  in  WIDTH  key to look up
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_code  out  WIDTH  mapped code, or MISS_CODE on miss
- out_hit  out  1  1 = some enabled entry matched
- out_idx  out  IDXW  lowest matching index; 0 on miss
- hit_cnt  out  CNTW  accepted results with hit=1, saturating
- miss_cnt  out  CNTW  accepted results with hit=0, saturating

Behaviour:
- Reset:
  - All entry enables clear; keys/codes need not clear.
  - Pipeline valids clear; out_valid=0, out_code=0, out_hit=0, out_idx=0.
  - hit_cnt=0, miss_cnt=0.
  - rst dominates cfg_we and in-flight data; in-flight words are dropped.
- Table write: on cfg_we, entry cfg_addr gets {cfg_key, cfg_code, cfg_en} at the clock edge. cfg_addr >= DEPTH is ignored.
- Stage 1 (acceptance cycle):
  - Compare in_data against all enabled entries, priority-encode to the lowest index, capture hit/idx/code into S1 registers.
  - The table used is the state before any write in the same cycle: a write and a lookup of the same entry in one cycle use the old entry.
- Stage 2: S1 result moves into the output registers. The S1 snapshot is immune to later table writes.
- Latency: word accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles with no stall.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational, no dependence on in_valid.
  - Transfer on valid&&ready at each interface.
  - Full throughput of 1 word/cycle when out_ready stays high.
- Stall: out_valid=1 and out_ready=0 hold out_* stable and hold S1. in_ready drops only when both stages are full.
- Ordering: in-order, no drop, no duplication.
- Miss: out_hit=0, out_idx=0, out_code=MISS_CODE.
- Multiple matches: lowest index wins.
- Counters:
  - Increment on out_valid&&out_ready, by hit or miss.
  - Saturate at 2^CNTW-1 with no wrap.
  - Readable any time; cleared only by rst.

Test Plan:
- Reset, then program e0={0,1423,1} and e1={123,0xFFFFFA70,1}. Send 0, then 123, with out_ready=1 -> codes 1423 (idx0, hit) then 0xFFFFFA70 (idx1, hit). Each appears 2 cycles after acceptance; hit_cnt=2.
- Send 7000 with no matching entry -> out_code=MISS_CODE(0), out_hit=0, out_idx=0, miss_cnt=1.
- Program e2={1023,5,1} and e5={1023,9,1}, send 1023 -> code 5, idx 2. Then write e2 with cfg_en=0 and send 1023 -> code 9, idx 5.
- Hold out_ready=0, offer 3 back-to-back words -> 2 accepted, in_ready=0 on the third, outputs stable. Release -> all 3 emerge in order, 1/cycle.
- In the same cycle, write e0={0,77,1} and accept key 0 -> result 1423 (old entry). Next key 0 -> 77.
- Force CNTW=4 and send 20 hits -> hit_cnt stays at 15. Assert rst with 2 words in flight -> out_valid=0 next cycle, counters 0, entries disabled.
